// File: rtl/aes_key_expand_seq_pkg.sv
// aes_key_expand_seq_pkg: AES-128 key-schedule constants, FSM state type and shared S-box/Rcon lookups.
package aes_key_expand_seq_pkg;
    localparam int NR     = 10;
    localparam int RK_W   = 128;
    localparam int WORD_W = 32;
    localparam int EXP_W  = (NR + 1) * RK_W;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    // byte x lives at [2047-8*x -: 8]
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [87:0] RCON = 88'h00_01_02_04_08_10_20_40_80_1b_36;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[11'd2047 - {x, 3'b000} -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        return RCON[7'd87 - {r, 3'b000} -: 8];
    endfunction
endpackage

// File: rtl/aes_key_expand_seq_subword.sv
// aes_subword: 32-bit SubWord from four lookups into the shared AES S-box table.
module aes_subword
    import aes_key_expand_seq_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    output logic [WORD_W-1:0] word_o
);
    for (genvar g = 0; g < 4; g++) begin : g_byte
        assign word_o[8*g +: 8] = sbox(word_i[8*g +: 8]);
    end
endmodule

// File: rtl/aes_key_expand_seq.sv
// aes_key_expand_seq: iterative AES-128 key schedule, one round key per clock into the packed w bus.
// Define AES_KEYEXP_RESTART_EN to let a start during RUN abort and restart from the new key.
module aes_key_expand_seq
    import aes_key_expand_seq_pkg::*;
#(
    parameter int NR = aes_key_expand_seq_pkg::NR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [RK_W-1:0]  key,
    output logic [EXP_W-1:0] w,
    output logic             busy,
    output logic             valid,
    output logic             done
);
    if (NR != 10) begin : g_bad_nr
        $error("aes_key_expand_seq supports only NR=10");
    end

    state_e                 state_q, state_d;
    logic [3:0]             rc_q, rc_d;
    logic [10:0][RK_W-1:0]  rk_q, rk_d;
    logic                   busy_q, busy_d, valid_q, valid_d, done_q, done_d;
    logic                   accept;
    logic [RK_W-1:0]        prev, next_rk;
    logic [WORD_W-1:0]      sub, t, n0, n1, n2, n3;

`ifdef AES_KEYEXP_RESTART_EN
    assign accept = start;
`else
    assign accept = start && state_q != RUN;
`endif

    // round key r is stored at element 10-r so rk0 lands in the MSBs of w
    assign prev = rk_q[4'd11 - rc_q];

    aes_subword u_subword (
        .word_i({prev[23:0], prev[31:24]}),
        .word_o(sub)
    );

    assign t       = sub ^ {rcon(rc_q), 24'h0};
    assign n0      = prev[127:96] ^ t;
    assign n1      = prev[95:64] ^ n0;
    assign n2      = prev[63:32] ^ n1;
    assign n3      = prev[31:0] ^ n2;
    assign next_rk = {n0, n1, n2, n3};

    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        rk_d    = rk_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        if (accept) begin
            state_d  = RUN;
            rk_d[10] = key;
            rc_d     = 4'd1;
            busy_d   = 1'b1;
            valid_d  = 1'b0;
        end else if (state_q == RUN) begin
            rk_d[4'd10 - rc_q] = next_rk;
            rc_d               = rc_q + 4'd1;
            if (rc_q == 4'(NR)) begin
                state_d = DONE;
                rc_d    = 4'd0;
                busy_d  = 1'b0;
                valid_d = 1'b1;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rc_q    <= 4'd0;
            rk_q    <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
            rk_q    <= rk_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign w     = rk_q;
    assign busy  = busy_q;
    assign valid = valid_q;
    assign done  = done_q;
endmodule

// File: tb/tb_aes_key_expand_seq.sv
// tb_aes_key_expand_seq: directed AES-128 key-schedule bench with a FIPS-197 word-level model
// (S-box derived from GF(2^8) inversion) checked against the DUT every cycle.
module tb_aes_key_expand_seq;
`ifdef AES_KEYEXP_RESTART_EN
    localparam bit RESTART = 1'b1;
`else
    localparam bit RESTART = 1'b0;
`endif
    localparam logic [127:0] K_FIPS    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [127:0]  key = '0;
    logic [1407:0] w;
    logic          busy, valid, done;

    int total = 0, passed = 0, done_cnt = 0, n;
    bit chk_en = 1'b0;
    logic [1407:0] m_w, m_tgt, tmp;
    logic          m_busy, m_valid, m_done, m_run;
    int            m_k;

    always #5 clk = ~clk;

    aes_key_expand_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key(key),
        .w(w), .busy(busy), .valid(valid), .done(done)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        logic [15:0] d;
        d = {b, b} << k;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox_m(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        if (x == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [1407:0] expand(input logic [127:0] k);
        logic [31:0]   wd [44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1407:0] o;
        for (int i = 0; i < 4; i++) wd[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = wd[i-1];
            if (i % 4 == 0) begin
                rc = 8'h01;
                for (int j = 1; j < i / 4; j++) rc = gmul(rc, 8'h02);
                t = {sbox_m(t[23:16]), sbox_m(t[15:8]), sbox_m(t[7:0]), sbox_m(t[31:24])} ^ {rc, 24'h0};
            end
            wd[i] = wd[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) o[1407-32*i -: 32] = wd[i];
        return o;
    endfunction

    task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %h want %h", nm, a, e);
    endtask

    task automatic chkw(input string nm, input logic [1407:0] a, input logic [1407:0] e);
        total++;
        if (a === e) passed++;
        else begin
            for (int r = 0; r < 11; r++)
                if (a[1407-128*r -: 128] !== e[1407-128*r -: 128]) begin
                    $display("FAIL %s rk%0d: got %h want %h", nm, r, a[1407-128*r -: 128], e[1407-128*r -: 128]);
                    break;
                end
        end
    endtask

    // reference: full expansion computed at acceptance, revealed one round key per edge
    always @(posedge clk) begin
        if (!rst_n) begin
            m_w <= '0; m_busy <= 1'b0; m_valid <= 1'b0; m_done <= 1'b0; m_run <= 1'b0; m_k <= 0;
        end else begin
            m_done <= 1'b0;
            if (start && (!m_run || RESTART)) begin
                m_tgt <= expand(key);
                m_w[1407 -: 128] <= key;
                m_k <= 1; m_run <= 1'b1; m_busy <= 1'b1; m_valid <= 1'b0;
            end else if (m_run) begin
                m_w[1407-128*m_k -: 128] <= m_tgt[1407-128*m_k -: 128];
                m_k <= m_k + 1;
                if (m_k == 10) begin
                    m_run <= 1'b0; m_busy <= 1'b0; m_valid <= 1'b1; m_done <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (chk_en) begin
            chkw("cyc_w", w, m_w);
            chk("cyc_busy", 128'(busy), 128'(m_busy));
            chk("cyc_valid", 128'(valid), 128'(m_valid));
            chk("cyc_done", 128'(done), 128'(m_done));
        end
    end

    task automatic tick(input int c);
        repeat (c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [127:0] k);
        start = 1'b1;
        key   = k;
        tick(1);
        start = 1'b0;
        key   = ~k;
    endtask

    task automatic wait_valid(output int c);
        c = 0;
        while (!valid && c < 30) begin
            tick(1);
            c++;
        end
        if (!valid) begin
            total++;
            $display("FAIL wait_valid: valid still %b after %0d edges, want 1", valid, c);
        end
    endtask

    initial begin
        tick(2);
        chk_en = 1'b1;
        chkw("reset_w", w, '0);
        chk("reset_busy", 128'(busy), 128'(1'b0));
        chk("reset_valid", 128'(valid), 128'(1'b0));
        chk("reset_done", 128'(done), 128'(1'b0));
        rst_n = 1'b1;
        tick(1);

        tmp = expand(K_FIPS);
        chk("model_fips_rk1", tmp[1279 -: 128], FIPS_RK1);
        chk("model_fips_rk10", tmp[127:0], FIPS_RK10);
        tmp = expand('0);
        chk("model_zero_rk1", tmp[1279 -: 128], ZERO_RK1);
        chk("model_zero_rk10", tmp[127:0], ZERO_RK10);

        done_cnt = 0;
        pulse(K_FIPS);
        chk("fips_busy_accept", 128'(busy), 128'(1'b1));
        wait_valid(n);
        chk("fips_latency", 128'(n), 128'd10);
        chk("fips_rk0", w[1407 -: 128], K_FIPS);
        chk("fips_rk1", w[1279 -: 128], FIPS_RK1);
        chk("fips_rk10", w[127:0], FIPS_RK10);
        tick(2);
        chk("fips_done_pulses", 128'(done_cnt), 128'd1);

        pulse('0);
        wait_valid(n);
        chk("zero_rk1", w[1279 -: 128], ZERO_RK1);
        chk("zero_rk10", w[127:0], ZERO_RK10);
        tick(1);

        done_cnt = 0;
        pulse(K_FIPS);
        tick(3);
        pulse('0);
        wait_valid(n);
        chk("midstart_latency", 128'(n), RESTART ? 128'd10 : 128'd6);
        chk("midstart_rk10", w[127:0], RESTART ? ZERO_RK10 : FIPS_RK10);
        chkw("midstart_w", w, RESTART ? expand('0) : expand(K_FIPS));
        tick(2);
        chk("midstart_done_pulses", 128'(done_cnt), 128'd1);

        pulse(K_FIPS);
        tick(4);
        rst_n = 1'b0;
        tick(1);
        chkw("midrst_w", w, '0);
        chk("midrst_busy", 128'(busy), 128'(1'b0));
        chk("midrst_valid", 128'(valid), 128'(1'b0));
        rst_n = 1'b1;
        tick(1);
        pulse('0);
        wait_valid(n);
        chk("after_rst_latency", 128'(n), 128'd10);
        chk("after_rst_rk10", w[127:0], ZERO_RK10);
        tick(1);

        done_cnt = 0;
        pulse(K_FIPS);
        chk("b2b_valid_drop", 128'(valid), 128'(1'b0));
        chk("b2b_rk0", w[1407 -: 128], K_FIPS);
        chk("b2b_busy", 128'(busy), 128'(1'b1));
        wait_valid(n);
        chk("b2b_latency", 128'(n), 128'd10);
        chkw("b2b_w", w, expand(K_FIPS));
        chk("b2b_rk10", w[127:0], FIPS_RK10);
        tick(2);
        chk("b2b_done_pulses", 128'(done_cnt), 128'd1);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
